// File: rtl/speed_ctrl.sv
// speed_ctrl: turns bouncing up/down push-buttons into a saturating 4-bit
// speed level and paces the game engine with a one-cycle tick whose period
// is PRESCALE * (16 - applied level) clock cycles.
module speed_ctrl #(
    parameter int PRESCALE        = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int MAX_LEVEL       = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       up_btn,
    input  logic       down_btn,
    input  logic       pause,
    output logic [3:0] level,
    output logic       level_chg,
    output logic       tick
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [3:0]     MAX_LVL = 4'(MAX_LEVEL);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

    // Bit 0 carries the up button, bit 1 the down button.
    logic [1:0]     raw;
    logic [1:0]     sync_a;
    logic [1:0]     sync_b;
    logic [1:0]     deb;
    logic [1:0]     deb_d;
    logic [DBW-1:0] db_cnt [2];
    logic [1:0]     press;

    logic [3:0]     next_level;

    logic [PSW-1:0] pres_cnt;
    logic [3:0]     step_cnt;
    logic [3:0]     applied;
    logic           strobe;
    logic           step_last;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= MAX_LVL) ? MAX_LVL : v + 4'd1;
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] v);
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
    endfunction

    assign raw = {down_btn, up_btn};

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Debounce: accept a new value only after DEBOUNCE_CYCLES consecutive
    // differing samples; any sample matching the accepted state restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // Delayed debounced state so a press is a single-cycle rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_d <= '0;
        end else begin
            deb_d <= deb;
        end
    end

    assign press = deb & ~deb_d;

    // Level arbitration: simultaneous up and down presses cancel out.
    always_comb begin
        next_level = level;
        unique case (press)
            2'b01:   next_level = sat_inc(level);
            2'b10:   next_level = sat_dec(level);
            default: next_level = level;
        endcase
    end

    // Registered level; the change pulse fires only on a real value change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level     <= 4'd0;
            level_chg <= 1'b0;
        end else begin
            level     <= next_level;
            level_chg <= (next_level != level);
        end
    end

    assign strobe    = !pause && (pres_cnt == PS_LAST);
    assign step_last = (step_cnt == (4'd15 - applied));

    // Tick generator: prescaler feeds a step counter whose target is fixed
    // for the whole period; the requested level is adopted only at a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pres_cnt <= '0;
            step_cnt <= 4'd0;
            applied  <= 4'd0;
            tick     <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (!pause) begin
                if (pres_cnt == PS_LAST) begin
                    pres_cnt <= '0;
                end else begin
                    pres_cnt <= pres_cnt + PSW'(1);
                end
            end
            if (strobe) begin
                if (step_last) begin
                    step_cnt <= 4'd0;
                    tick     <= 1'b1;
                    applied  <= level;
                end else begin
                    step_cnt <= step_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: doc/speed_ctrl.md
# speed_ctrl

Game-speed controller that turns the raw up/down push-buttons into a saturating 4-bit speed level and generates the periodic one-cycle `tick` enable that paces the game engine. It replaces free-running button-clocked logic with fully synchronous sequencing on the system clock: input synchronization, debouncing, press detection, level arbitration and glitch-free period switching. It sits between the board buttons and every block that advances game state on `tick`.

## Interface
- `PRESCALE`, default 4: clk cycles per base step; must be ≥ 1.
- `DEBOUNCE_CYCLES`, default 8: consecutive stable samples required before a button change is accepted; must be ≥ 1.
- `MAX_LEVEL`, default 15: highest level, ≤ 15.
- `clk` input, 1: system clock; all state changes on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `up_btn` input, 1: raw, asynchronous, bouncing "faster" button, active-high.
- `down_btn` input, 1: raw, asynchronous, bouncing "slower" button, active-high.
- `pause` input, 1: synchronous; freezes tick generation while high.
- `level` output, 4: requested speed level, 0 (slowest) to MAX_LEVEL.
- `level_chg` output, 1: one-cycle pulse on the edge where `level` changes.
- `tick` output, 1: one-cycle game-step enable.

## Operation
- Reset values: `level` = 0, `level_chg` = 0, `tick` = 0, applied level = 0. All synchronizers, debounced states and counters are 0.
- Input path, per button:
  - Two-flop synchronizer.
  - Debounce counter. When the synchronized value differs from the debounced state, the counter increments. When it reaches DEBOUNCE_CYCLES, the debounced state takes the synchronized value and the counter clears.
  - Any sample equal to the debounced state clears the counter.
- Press event: a 0→1 transition of the debounced state, one event per press. Release generates nothing.
- Level arbitration, on the cycle a press event is seen:
  - Up only: `level` +1, saturating at MAX_LEVEL.
  - Down only: `level` −1, saturating at 0.
  - Up and down on the same cycle: no change.
  - `level_chg` pulses only if the value actually changed. It does not pulse at either saturation limit.
- Tick generator:
  - The prescaler counts 0..PRESCALE−1 and emits a base strobe on wrap.
  - The step counter counts base strobes up to a target of 16 − applied level.
  - On reaching the target, it asserts `tick`, clears, and loads applied level ← `level`.
  - Resulting tick period = PRESCALE × (16 − applied level) cycles.
- Period switching: a level change never truncates or stretches the period in progress. The new level applies starting with the period after the next `tick`.
- Pause: while `pause` = 1, the prescaler and step counter hold and `tick` = 0. On release, counting resumes from the held values. Level changes are still accepted while paused.
- Reset mid-operation: all state returns to reset values immediately. A button held through reset release is seen as a fresh press once it is debounced.

## Timing
- Button latency: let N be the first edge at which the raw input is high, held stable. Then `level` and `level_chg` change at edge N + DEBOUNCE_CYCLES + 2.
- A bounce shorter than DEBOUNCE_CYCLES consecutive cycles produces no event.
- `tick` is exactly one cycle wide. The first `tick` after reset comes PRESCALE × 16 cycles after `rst_n` deasserts.
- Ticks are never back-to-back unless PRESCALE = 1 and applied level = 15; then `tick` is high every cycle.
- `level` is registered, with no combinational path from the buttons.

## Test plan
- Reset, PRESCALE=4, no buttons: first `tick` after 64 cycles, then every 64 cycles. `level` = 0 and `level_chg` = 0 throughout.
- Five clean up presses, each held 20 cycles: `level` steps 0→5 with five `level_chg` pulses. The tick period becomes 44 cycles, starting with the period after the first `tick` following the fifth press.
- Up press with 3 bounces of 2 to 5 cycles before settling: exactly one increment, at N + 10 after the stable edge.
- Sixteen up presses from level 14: `level` stays at 15, with one `level_chg` pulse only. Ticks then come every 4 cycles. Down presses at level 0 likewise leave `level` at 0 with no `level_chg`.
- Up and down debounced on the same cycle at level 7: `level` stays 7, no `level_chg`.
- Assert `pause` for 100 cycles mid-period at level 0: no `tick` during the pause. The remaining period completes after release, with the total unpaused count equal to 64. A reset pulse mid-period restores `level` = 0 and restarts the first-tick countdown of 64 cycles.
